muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in DATA_WIDTH.
- Sits beside the combinational ALU in the execute stage and covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Multi-cycle: one shift-add or restoring-subtract step per clock.
- Valid/ready handshakes on input and output, plus a flush input for pipeline squash.

---
 rtl/muldiv_unit.sv | 145 ++++++++++++++
 tb/tb_muldiv_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-subtract step per clock.
module muldiv_unit #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    Result,
    output logic                     busy
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W);
    localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);
    localparam logic [W-1:0]  MIN_VAL   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic [W-1:0]    a_mag_q, b_mag_q;
    logic            neg_q, a_neg_q;
    logic [2*W-1:0]  acc_q;
    logic [CW-1:0]   step_q;

    logic            accept, signed_a, signed_b, a_neg, b_neg;
    logic            div_zero, div_ovf, special;
    logic [W-1:0]    a_mag, b_mag, special_res, final_res;
    logic [W:0]      mul_sum, div_diff;
    logic [2*W-1:0]  mul_next, div_next, acc_step, prod;
    logic [W-1:0]    quo_f, rem_f;

    assign accept = in_valid && (state_q == IDLE) && !flush;

    // Operand signedness by opcode, magnitudes and special-case detection at acceptance
    always_comb begin
        signed_a = 1'b1;
        signed_b = 1'b1;
        case (Operation[2:0])
            3'b010:                 signed_b = 1'b0;
            3'b011, 3'b101, 3'b111: begin
                signed_a = 1'b0;
                signed_b = 1'b0;
            end
            default: ;
        endcase
        a_neg    = signed_a && SrcA[W-1];
        b_neg    = signed_b && SrcB[W-1];
        a_mag    = a_neg ? (~SrcA + W'(1)) : SrcA;
        b_mag    = b_neg ? (~SrcB + W'(1)) : SrcB;
        div_zero = Operation[2] && (SrcB == '0);
        div_ovf  = Operation[2] && !Operation[0] && (SrcA == MIN_VAL) && (SrcB == '1);
        special  = div_zero || div_ovf;
        if (div_zero) special_res = Operation[1] ? SrcA : '1;
        else          special_res = Operation[1] ? '0 : MIN_VAL;
    end

    // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, a_mag_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};
        div_diff = acc_q[2*W-1:W-1] - {1'b0, b_mag_q};
        div_next = div_diff[W] ? {acc_q[2*W-2:0], 1'b0}
                               : {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
        acc_step = op_q[2] ? div_next : mul_next;
        prod     = neg_q ? (~acc_step + (2*W)'(1)) : acc_step;
        quo_f    = neg_q ? (~acc_step[W-1:0] + W'(1)) : acc_step[W-1:0];
        rem_f    = a_neg_q ? (~acc_step[2*W-1:W] + W'(1)) : acc_step[2*W-1:W];
        case (op_q)
            3'b000:                 final_res = prod[W-1:0];
            3'b001, 3'b010, 3'b011: final_res = prod[2*W-1:W];
            3'b100, 3'b101:         final_res = quo_f;
            default:                final_res = rem_f;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush)                    state_d = IDLE;
                else if (step_q == LAST_STEP) state_d = DONE;
            end
            DONE: if (flush || out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register and state-decoded handshake outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q    <= '0;
            a_mag_q <= '0;
            b_mag_q <= '0;
            neg_q   <= 1'b0;
            a_neg_q <= 1'b0;
            acc_q   <= '0;
            step_q  <= '0;
            Result  <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_q    <= Operation[2:0];
                    a_mag_q <= a_mag;
                    b_mag_q <= b_mag;
                    neg_q   <= a_neg ^ b_neg;
                    a_neg_q <= a_neg;
                    acc_q   <= Operation[2] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                    step_q  <= '0;
                    if (special) Result <= special_res;
                end
                CALC: if (!flush) begin
                    acc_q  <= acc_step;
                    step_q <= step_q + CW'(1);
                    if (step_q == LAST_STEP) Result <= final_res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [31:0] SrcA, SrcB, Result;
    logic [2:0]  Operation;
    int          total, bad;

    muldiv_unit #(.DATA_WIDTH(32), .OPCODE_LENGTH(3)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .out_valid(out_valid), .out_ready(out_ready),
        .Result(Result), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one operation and return #1 after its acceptance edge
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int g;
        g = 0;
        while (!in_ready && g < 100) begin @(posedge clk); #1; g++; end
        in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b;
        @(posedge clk); #1;
        in_valid = 1'b0; SrcA = $urandom; SrcB = $urandom; Operation = 3'($urandom);
    endtask

    // Wait for out_valid, then check latency and result
    task automatic collect(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 1;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, "_lat"}, 32'(n), 32'(exp_latency(op, a, b)));
        chk({tag, "_res"}, Result, model(op, a, b));
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        out_ready = 1'b1;
        issue(op, a, b);
        collect(tag, op, a, b);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] held, ra, rb;
        logic [2:0]  rop;
        logic        seen;
        total = 0; bad = 0;
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        SrcA = '0; SrcB = '0; Operation = '0;

        // Reset sequence
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", Result, 32'd0);

        // Flush in IDLE blocks acceptance
        @(posedge clk); #1;
        in_valid = 1'b1; flush = 1'b1; Operation = 3'd0; SrcA = 32'd2; SrcB = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("idle_flush_busy", 32'(busy), 32'd0);
        chk("idle_flush_ready", 32'(in_ready), 32'd1);

        // Directed multiply, divide and special cases
        run_op("mul_7", 3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op("mulh_min", 3'd1, MIN, MIN);
        run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_neg", 3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op("rem_neg", 3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op("divu", 3'd5, 32'hFFFF_FFF9, 32'd2);
        run_op("remu", 3'd7, 32'hFFFF_FFF9, 32'd2);
        run_op("div_zero", 3'd4, 32'd5, 32'd0);
        run_op("remu_zero", 3'd7, 32'd5, 32'd0);
        run_op("div_ovf", 3'd4, MIN, 32'hFFFF_FFFF);
        run_op("rem_ovf", 3'd6, MIN, 32'hFFFF_FFFF);

        // Backpressure, then the queued MUL 3*4 after one IDLE cycle
        out_ready = 1'b0;
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        collect("bp", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        held = Result;
        in_valid = 1'b1; Operation = 3'd0; SrcA = 32'd3; SrcB = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        chk("bp_stable", Result, held);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("b2b_idle_ready", 32'(in_ready), 32'd1);
        chk("b2b_idle_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b_accept_busy", 32'(busy), 32'd1);
        collect("b2b_mul", 3'd0, 32'd3, 32'd4);
        @(posedge clk); #1;

        // Flush part-way through a DIV
        issue(3'd4, 32'h7654_3210, 32'd13);
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        chk("flush_no_valid", 32'(seen), 32'd0);

        // Reset part-way through a MUL
        issue(3'd0, 32'hDEAD_BEEF, 32'h0BAD_F00D);
        repeat (19) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", Result, 32'd0);
        run_op("post_rst_mulhu", 3'd3, 32'hCAFE_BABE, 32'h8765_4321);

        // Randomized operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = 3'($urandom);
            ra  = pick();
            rb  = pick();
            run_op($sformatf("rand%0d_op%0d", i, rop), rop, ra, rb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
